// File: rtl/instr_fetcher_cache.sv
// Per-core instruction fetcher with a direct-mapped, one-instruction-per-line cache.
// Answers the scheduler's FETCH/DECODE handshake and refills misses over a valid/ready read channel.
module instr_fetcher_cache #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 8,
    parameter int COUNTER_BITS          = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [7:0]                       current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [COUNTER_BITS-1:0]          hit_count,
    output logic [COUNTER_BITS-1:0]          miss_count
);

    localparam int INDEX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS;

    localparam logic [2:0] CORE_FETCH  = 3'd1;
    localparam logic [2:0] CORE_DECODE = 3'd2;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_FETCHING = 3'd1,
        FS_FETCHED  = 3'd2
    } fetch_state_t;

    fetch_state_t state;

    logic [CACHE_LINES-1:0]           line_valid;
    logic [TAG_BITS-1:0]              line_tag  [CACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_LINES];

    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_addr;
    logic [INDEX_BITS-1:0]            lookup_index;
    logic [TAG_BITS-1:0]              lookup_tag;
    logic [INDEX_BITS-1:0]            fill_index;
    logic [TAG_BITS-1:0]              fill_tag;
    logic                             lookup_en;
    logic                             lookup_hit;
    logic                             fill_blocked;
    logic                             fill_en;

    function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    assign pc_addr      = PROGRAM_MEM_ADDR_BITS'(current_pc);
    assign lookup_index = pc_addr[INDEX_BITS-1:0];
    assign lookup_tag   = pc_addr[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];
    assign fill_index   = mem_read_address[INDEX_BITS-1:0];
    assign fill_tag     = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];

    // The lookup reads the pre-flush contents, so a flush alongside a hit still hits.
    assign lookup_en  = (state == FS_IDLE) && (core_state == CORE_FETCH);
    assign lookup_hit = line_valid[lookup_index] && (line_tag[lookup_index] == lookup_tag);

    // A flush seen at any point of an outstanding miss keeps its data out of the cache.
    assign fill_en = (state == FS_FETCHING) && mem_read_ready && !fill_blocked && !flush;

    assign fetcher_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= FS_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            hit_count        <= '0;
            miss_count       <= '0;
            line_valid       <= '0;
            fill_blocked     <= 1'b0;
        end else begin
            unique case (state)
                FS_IDLE: begin
                    if (lookup_en) begin
                        if (lookup_hit) begin
                            state       <= FS_FETCHED;
                            instruction <= line_data[lookup_index];
                            hit_count   <= sat_inc(hit_count);
                        end else begin
                            state            <= FS_FETCHING;
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= pc_addr;
                            miss_count       <= sat_inc(miss_count);
                            fill_blocked     <= 1'b0;
                        end
                    end
                end
                FS_FETCHING: begin
                    if (flush) begin
                        fill_blocked <= 1'b1;
                    end
                    if (mem_read_ready) begin
                        state          <= FS_FETCHED;
                        mem_read_valid <= 1'b0;
                        instruction    <= mem_read_data;
                    end
                end
                FS_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state <= FS_IDLE;
                    end
                end
                default: begin
                    state          <= FS_IDLE;
                    mem_read_valid <= 1'b0;
                end
            endcase

            if (flush) begin
                line_valid <= '0;
            end else if (fill_en) begin
                line_valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            line_tag[fill_index]  <= fill_tag;
            line_data[fill_index] <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_instr_fetcher_cache.sv
// Randomised scoreboard bench for instr_fetcher_cache against an address-level cache model.
// A responder plays program memory; a monitor checks every FETCHED delivery against the queue.
module tb_instr_fetcher_cache;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LINES = 8;
    localparam int CB    = 4;
    localparam int CMAX  = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    core_state;
    logic [7:0]    current_pc;
    logic          flush;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;
    logic [CB-1:0] hit_count;
    logic [CB-1:0] miss_count;

    instr_fetcher_cache #(
        .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW),
        .CACHE_LINES(LINES),
        .COUNTER_BITS(CB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .current_pc(current_pc),
        .flush(flush),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] instr;
        bit            hit;
        int            hits;
        int            misses;
    } exp_t;

    exp_t sb[$];

    logic [DW-1:0] prog_mem [256];
    bit            m_valid  [LINES];
    logic [7:0]    m_pc     [LINES];
    logic [DW-1:0] m_data   [LINES];
    int            m_hits;
    int            m_misses;

    int            checks = 0;
    int            passes = 0;
    logic [7:0]    exp_addr = 8'h00;
    bit            resp_hold = 1'b0;
    bit            stray_force = 1'b0;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("[TB] FAIL %s: got no valid event, expected one", name);
    endtask

    task automatic model_invalidate();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic logic [2:0] pick_busy();
        logic [2:0] v;
        do v = 3'($urandom_range(0, 7)); while (v == 3'd2);
        return v;
    endfunction

    // Program memory: random latency on requests, random stray strobes when idle.
    int wait_cnt = 0;
    int delay = 0;
    always @(negedge clk) begin
        if (resp_hold) begin
            mem_read_ready = stray_force;
            mem_read_data  = 16'hBEEF;
            wait_cnt       = 0;
        end else if (mem_read_valid) begin
            if (wait_cnt >= delay) begin
                mem_read_ready = 1'b1;
                mem_read_data  = prog_mem[mem_read_address];
                wait_cnt       = 0;
                delay          = $urandom_range(0, 3);
            end else begin
                mem_read_ready = 1'b0;
                mem_read_data  = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            mem_read_ready = ($urandom_range(0, 3) == 0);
            mem_read_data  = 16'($urandom);
            wait_cnt       = 0;
        end
    end

    // Monitor: every entry into FETCHED consumes one scoreboard entry.
    logic [2:0]    prev_state = 3'd0;
    logic [DW-1:0] held = '0;
    bit            mem_seen = 1'b0;
    exp_t          got;
    always @(negedge clk) begin
        if (reset) begin
            prev_state = 3'd0;
            mem_seen   = 1'b0;
        end else begin
            if (mem_read_valid) begin
                mem_seen = 1'b1;
                check_output("mem_addr", mem_read_address, exp_addr);
            end
            if (fetcher_state == 3'd2 && prev_state != 3'd2) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_fetched");
                end else begin
                    got = sb.pop_front();
                    check_output("instruction", instruction, got.instr);
                    check_output("hit_count", hit_count, got.hits);
                    check_output("miss_count", miss_count, got.misses);
                    check_output("mem_used", mem_seen, !got.hit);
                end
                held = instruction;
            end else if (fetcher_state == 3'd2) begin
                check_output("instr_hold", instruction, held);
            end
            if (fetcher_state == 3'd0) mem_seen = 1'b0;
            prev_state = fetcher_state;
        end
    end

    // flush_mode: 0 none, 1 with lookup, 2 one cycle after lookup, 3 after DECODE
    task automatic apply_stimulus(input logic [7:0] pc, input int flush_mode);
        int      line;
        int      n;
        bit      hit;
        exp_t    e;
        @(negedge clk);
        line = int'(pc) % LINES;
        hit  = m_valid[line] && (m_pc[line] == pc);
        core_state = 3'd1;
        current_pc = pc;
        flush      = (flush_mode == 1);
        if (hit) begin
            m_hits = sat(m_hits);
            e.instr = m_data[line];
        end else begin
            m_misses = sat(m_misses);
            e.instr  = prog_mem[pc];
            exp_addr = pc;
        end
        e.hit = hit;
        e.hits = m_hits;
        e.misses = m_misses;
        sb.push_back(e);
        if (flush_mode == 1) model_invalidate();

        @(negedge clk);
        flush      = 1'b0;
        current_pc = 8'($urandom);
        core_state = pick_busy();
        if (hit) begin
            check_output("hit_latency", fetcher_state, 2);
        end else begin
            check_output("miss_state", fetcher_state, 1);
            check_output("miss_valid", mem_read_valid, 1);
        end
        if (flush_mode == 2) begin
            flush = 1'b1;
            model_invalidate();
        end

        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (fetcher_state != 3'd2 && n < 30) begin
            core_state = pick_busy();
            @(negedge clk);
            n++;
        end
        if (fetcher_state != 3'd2) fail_now("fetch_timeout");
        if (!hit && flush_mode != 2) begin
            m_valid[line] = 1'b1;
            m_pc[line]    = pc;
            m_data[line]  = prog_mem[pc];
        end

        repeat ($urandom_range(0, 2)) begin
            core_state = pick_busy();
            @(negedge clk);
        end
        core_state = 3'd2;
        @(negedge clk);
        check_output("decode_return", fetcher_state, 0);
        core_state = 3'd0;
        if (flush_mode == 3) begin
            flush = 1'b1;
            model_invalidate();
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        core_state = 3'd0;
        current_pc = 8'd0;
        for (int i = 0; i < 256; i++) prog_mem[i] = 16'($urandom);
        prog_mem[8'h05] = 16'h3A21;
        prog_mem[8'h0D] = 16'h5C0D;
        model_invalidate();
        m_hits = 0;
        m_misses = 0;

        repeat (2) @(negedge clk);
        check_output("rst_state", fetcher_state, 0);
        check_output("rst_valid", mem_read_valid, 0);
        check_output("rst_addr", mem_read_address, 0);
        check_output("rst_instr", instruction, 0);
        check_output("rst_hits", hit_count, 0);
        check_output("rst_misses", miss_count, 0);
        reset = 1'b0;

        $display("[TB] directed: cold miss, hit, conflict, flush during miss");
        apply_stimulus(8'h05, 0);
        apply_stimulus(8'h05, 0);
        apply_stimulus(8'h0D, 0);
        apply_stimulus(8'h05, 0);
        apply_stimulus(8'h10, 2);
        apply_stimulus(8'h10, 0);
        apply_stimulus(8'h05, 1);
        apply_stimulus(8'h05, 0);

        $display("[TB] directed: reset during an outstanding miss");
        @(negedge clk);
        resp_hold   = 1'b1;
        stray_force = 1'b0;
        core_state  = 3'd1;
        current_pc  = 8'h2C;
        exp_addr    = 8'h2C;
        @(negedge clk);
        core_state = 3'd0;
        check_output("rm_fetching", fetcher_state, 1);
        check_output("rm_valid", mem_read_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_invalidate();
        m_hits = 0;
        m_misses = 0;
        check_output("rm_state", fetcher_state, 0);
        check_output("rm_valid_low", mem_read_valid, 0);
        check_output("rm_hits", hit_count, 0);
        check_output("rm_misses", miss_count, 0);
        stray_force = 1'b1;
        repeat (2) @(negedge clk);
        stray_force = 1'b0;
        resp_hold   = 1'b0;
        check_output("rm_stray_ignored", fetcher_state, 0);
        apply_stimulus(8'h2C, 0);

        $display("[TB] random traffic");
        repeat (150) begin
            int r;
            r = $urandom_range(0, 9);
            apply_stimulus(8'($urandom_range(0, 31)), (r < 7) ? 0 : r - 6);
        end

        $display("[TB] counter saturation");
        apply_stimulus(8'h21, 0);
        repeat (20) apply_stimulus(8'h21, 0);

        repeat (5) @(negedge clk);
        check_output("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetcher_cache.md
Name: instr_fetcher_cache

Overview:
Per-core instruction fetcher. It is the responder to the core scheduler's FETCH/DECODE handshake. It watches core_state and current_pc, serves instructions from a small direct-mapped instruction cache, and on a miss performs a valid/ready read on the program-memory channel. It reports progress on fetcher_state, which the scheduler polls to leave FETCH.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program memory address width (current_pc zero-extended or truncated to this width)
PROGRAM_MEM_DATA_BITS, 16, instruction width
CACHE_LINES, 8, number of direct-mapped one-instruction lines; power of 2, 2..64
COUNTER_BITS, 16, width of hit/miss counters

Ports:
clk  input  1  clock (only clock)
reset  input  1  synchronous, active-high reset
core_state  input  3  scheduler state: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7
current_pc  input  8  PC of the instruction to fetch
flush  input  1  invalidate all cache lines
mem_read_valid  output  1  program-memory read request
mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address
mem_read_ready  input  1  memory response strobe; data valid this cycle
mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction
fetcher_state  output  3  IDLE=0, FETCHING=1, FETCHED=2
instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction; held stable in FETCHED
hit_count  output  COUNTER_BITS  saturating count of cache hits
miss_count  output  COUNTER_BITS  saturating count of cache misses

Behaviour:
- Reset (synchronous, active-high) sets: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0, miss_count=0, all line valid bits=0. Reset mid-miss abandons the request; a later mem_read_ready is ignored.
- Index = current_pc[log2(CACHE_LINES)-1:0]. Tag = remaining address bits. Each line holds valid, tag, data.
- IDLE: when core_state==FETCH, perform the lookup using current_pc sampled this cycle.
  - Hit: next cycle fetcher_state=FETCHED, instruction=line data, hit_count+1. Latency 1 cycle. No memory request.
  - Miss: next cycle fetcher_state=FETCHING, mem_read_valid=1, mem_read_address=current_pc, miss_count+1.
- FETCHING: hold mem_read_valid and the address stable until mem_read_ready=1. In the cycle ready is seen:
  - next cycle: mem_read_valid=0, instruction=mem_read_data, fetcher_state=FETCHED
  - fill the line (valid=1, tag, data)
  - Minimum miss latency: 2 cycles from FETCH seen to FETCHED, with ready on the first valid cycle.
- mem_read_ready while not FETCHING is ignored.
- FETCHED: hold instruction. When core_state==DECODE, return to IDLE next cycle. Any other core_state keeps FETCHED.
- A new lookup requires IDLE and core_state==FETCH. While FETCHED, core_state==FETCH does not re-fetch.
- flush in IDLE/FETCHED: all valid bits clear next cycle; instruction and fetcher_state are unaffected.
- flush during FETCHING: the outstanding request completes and delivers the instruction normally, but its fill is suppressed (line stays invalid).
- flush in the same cycle as a hit lookup: the lookup uses the pre-flush contents (hit), then everything is invalidated.
- Counters saturate at all-ones and do not wrap.
- Same-index, different-tag fill replaces the line (no associativity).
- current_pc changes during FETCHING are ignored; the latched address is used.

Test Plan:
- Cold miss: reset, core_state=FETCH, pc=0x05; memory returns 0x3A21 after 3 cycles of valid -> mem_read_address=0x05 held 3 cycles; FETCHED with instruction=0x3A21; miss_count=1; DECODE returns to IDLE.
- Hit: repeat pc=0x05 -> FETCHED one cycle after FETCH, mem_read_valid never asserted, instruction=0x3A21, hit_count=1.
- Conflict: CACHE_LINES=8; fetch 0x05, then 0x0D (same index), then 0x05 -> three misses, 0 hits; data correct each time.
- Flush during miss: flush asserted while FETCHING pc=0x10 -> instruction delivered; the next fetch of 0x10 misses (miss_count increments).
- Reset mid-miss: reset while mem_read_valid=1, then a stray mem_read_ready -> state IDLE, valid=0, no fill; a fetch of the same pc misses.
- Saturation: COUNTER_BITS=4; 20 hits -> hit_count stays 15.
